// File: rtl/alu_issue_sched_if.sv
// Bus bundle between the reservation stations, the ALU issue scheduler and the ALU state unit.
// slave = scheduler side, master = RS/ALU side.
interface alu_issue_sched_if #(
  parameter int unsigned NUM_RS  = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LABEL_W = 4
);
  logic [NUM_RS-1:0]         rsReady;
  logic [2*NUM_RS-1:0]       rsOp;
  logic [DATA_W*NUM_RS-1:0]  rsData1;
  logic [DATA_W*NUM_RS-1:0]  rsData2;
  logic [LABEL_W*NUM_RS-1:0] rsLabel;
  logic                      flush;
  logic                      aluAvail;
  logic [NUM_RS-1:0]         rsGrant;
  logic                      aluWEN;
  logic [1:0]                aluOp;
  logic [DATA_W-1:0]         aluData1;
  logic [DATA_W-1:0]         aluData2;
  logic [LABEL_W-1:0]        aluLabel;
  logic [15:0]               issueCnt;
  logic [15:0]               stallCnt;

  modport slave (
    input  rsReady, rsOp, rsData1, rsData2, rsLabel, flush, aluAvail,
    output rsGrant, aluWEN, aluOp, aluData1, aluData2, aluLabel, issueCnt, stallCnt
  );

  modport master (
    output rsReady, rsOp, rsData1, rsData2, rsLabel, flush, aluAvail,
    input  rsGrant, aluWEN, aluOp, aluData1, aluData2, aluLabel, issueCnt, stallCnt
  );
endinterface

// File: rtl/alu_issue_sched.sv
// Round-robin issue scheduler: one ready RS entry per cycle into a registered ALU issue slot.
// Define ISSUE_STATS_EN to build the saturating issue/stall counters; otherwise they read 0.
module alu_issue_sched #(
  parameter int unsigned NUM_RS  = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned LABEL_W = 4
) (
  input  logic              clk,
  input  logic              nRST,
  alu_issue_sched_if.slave  bus
);
  localparam int unsigned PTR_W = $clog2(NUM_RS);
  localparam int unsigned CNT_W = 16;

  logic [PTR_W-1:0]   r_ptr;
  logic [NUM_RS-1:0]  r_mask;
  logic [NUM_RS-1:0]  r_grant;
  logic               r_wen;
  logic [1:0]         r_op;
  logic [DATA_W-1:0]  r_data1;
  logic [DATA_W-1:0]  r_data2;
  logic [LABEL_W-1:0] r_label;

  logic [NUM_RS-1:0]  w_eligible;
  logic [NUM_RS-1:0]  w_grant_oh;
  logic [PTR_W-1:0]   w_sel;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic               w_found;
  logic               w_consume;
  logic               w_slot_free;
  logic               w_grant_en;
  logic [1:0]         w_op;
  logic [DATA_W-1:0]  w_data1;
  logic [DATA_W-1:0]  w_data2;
  logic [LABEL_W-1:0] w_label;

  assign w_eligible  = bus.rsReady & ~r_mask;
  assign w_consume   = r_wen & bus.aluAvail;
  assign w_slot_free = ~r_wen | w_consume;
  assign w_grant_en  = w_slot_free & ~bus.flush & w_found;
  assign w_grant_oh  = NUM_RS'(1) << w_sel;
  assign w_ptr_nxt   = (w_sel == PTR_W'(NUM_RS - 1)) ? '0 : w_sel + PTR_W'(1);

  // First eligible entry scanning from r_ptr upward, wrapping at NUM_RS.
  always_comb begin : pick
    int unsigned v_idx;
    w_found = 1'b0;
    w_sel   = '0;
    v_idx   = 0;
    for (int unsigned k = 0; k < NUM_RS; k++) begin
      v_idx = 32'(r_ptr) + k;
      if (v_idx >= NUM_RS) v_idx = v_idx - NUM_RS;
      if (!w_found && w_eligible[PTR_W'(v_idx)]) begin
        w_found = 1'b1;
        w_sel   = PTR_W'(v_idx);
      end
    end
  end

  always_comb begin : payload_mux
    w_op    = '0;
    w_data1 = '0;
    w_data2 = '0;
    w_label = '0;
    for (int unsigned i = 0; i < NUM_RS; i++) begin
      if (w_sel == PTR_W'(i)) begin
        w_op    = bus.rsOp[2*i +: 2];
        w_data1 = bus.rsData1[DATA_W*i +: DATA_W];
        w_data2 = bus.rsData2[DATA_W*i +: DATA_W];
        w_label = bus.rsLabel[LABEL_W*i +: LABEL_W];
      end
    end
  end

  // Issue slot: flush beats consume; a consumed slot may be refilled at the same edge.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_ptr   <= '0;
      r_mask  <= '0;
      r_grant <= '0;
      r_wen   <= 1'b0;
      r_op    <= '0;
      r_data1 <= '0;
      r_data2 <= '0;
      r_label <= '0;
    end else if (bus.flush) begin
      r_wen   <= 1'b0;
      r_grant <= '0;
      r_mask  <= '0;
    end else if (w_grant_en) begin
      r_wen   <= 1'b1;
      r_grant <= w_grant_oh;
      r_mask  <= w_grant_oh;
      r_ptr   <= w_ptr_nxt;
      r_op    <= w_op;
      r_data1 <= w_data1;
      r_data2 <= w_data2;
      r_label <= w_label;
    end else begin
      r_grant <= '0;
      r_mask  <= '0;
      if (w_consume) r_wen <= 1'b0;
    end
  end

  assign bus.rsGrant  = r_grant;
  assign bus.aluWEN   = r_wen;
  assign bus.aluOp    = r_op;
  assign bus.aluData1 = r_data1;
  assign bus.aluData2 = r_data2;
  assign bus.aluLabel = r_label;

`ifdef ISSUE_STATS_EN
  logic [CNT_W-1:0] r_issue_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  // Saturating statistics; a flushed consume does not count as an issue.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_issue_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_consume && !bus.flush && (r_issue_cnt != {CNT_W{1'b1}}))
        r_issue_cnt <= r_issue_cnt + CNT_W'(1);
      if (r_wen && !bus.aluAvail && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign bus.issueCnt = r_issue_cnt;
  assign bus.stallCnt = r_stall_cnt;
`else
  assign bus.issueCnt = '0;
  assign bus.stallCnt = '0;
`endif
endmodule

// File: tb/tb_alu_issue_sched.sv
// Directed bench for alu_issue_sched: expected issues are queued when readiness is driven
// and popped when the DUT pulses rsGrant.
module tb_alu_issue_sched;
  localparam int unsigned NUM_RS  = 4;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned LABEL_W = 4;
`ifdef ISSUE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic clk  = 1'b0;
  logic nRST = 1'b0;

  alu_issue_sched_if #(.NUM_RS(NUM_RS), .DATA_W(DATA_W), .LABEL_W(LABEL_W)) bus ();

  alu_issue_sched #(.NUM_RS(NUM_RS), .DATA_W(DATA_W), .LABEL_W(LABEL_W)) dut (
    .clk  (clk),
    .nRST (nRST),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int q_exp[$];

  function automatic logic [1:0] ent_op(input int i);
    return 2'(i);
  endfunction
  function automatic logic [31:0] ent_d1(input int i);
    return 32'hA5A0_0000 + 32'(i) * 32'h0000_0111;
  endfunction
  function automatic logic [31:0] ent_d2(input int i);
    return 32'h5B00_1000 ^ (32'(i) << 8);
  endfunction
  function automatic logic [3:0] ent_lbl(input int i);
    return 4'(12 - i);
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_slot(input string tag, input int e);
    chk({tag, "_wen"},   128'(bus.aluWEN),   128'(1));
    chk({tag, "_op"},    128'(bus.aluOp),    128'(ent_op(e)));
    chk({tag, "_data1"}, 128'(bus.aluData1), 128'(ent_d1(e)));
    chk({tag, "_data2"}, 128'(bus.aluData2), 128'(ent_d2(e)));
    chk({tag, "_label"}, 128'(bus.aluLabel), 128'(ent_lbl(e)));
  endtask

  // One clock; sample just after the edge; pop the scoreboard when a grant shows up.
  task automatic step(input bit exp_grant);
    int e;
    @(posedge clk);
    #1;
    chk("grant_present", 128'(|bus.rsGrant), 128'(exp_grant));
    if (bus.rsGrant != '0) begin
      if (q_exp.size() == 0) begin
        chk("unexpected_grant", 128'(bus.rsGrant), 128'(0));
      end else begin
        e = q_exp.pop_front();
        chk("grant_vec", 128'(bus.rsGrant), 128'(4'b0001 << e));
        chk_slot("issue", e);
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_grant"}, 128'(bus.rsGrant), 128'(0));
    chk({tag, "_wen"},   128'(bus.aluWEN),  128'(0));
    chk({tag, "_payload"}, {58'd0, bus.aluOp, bus.aluData1, bus.aluData2, bus.aluLabel}, 128'(0));
    chk({tag, "_cnts"},  128'({bus.issueCnt, bus.stallCnt}), 128'(0));
  endtask

  initial begin
    for (int i = 0; i < int'(NUM_RS); i++) begin
      bus.rsOp[2*i +: 2]                = ent_op(i);
      bus.rsData1[DATA_W*i +: DATA_W]   = ent_d1(i);
      bus.rsData2[DATA_W*i +: DATA_W]   = ent_d2(i);
      bus.rsLabel[LABEL_W*i +: LABEL_W] = ent_lbl(i);
    end
    bus.rsReady  = '0;
    bus.flush    = 1'b0;
    bus.aluAvail = 1'b0;

    // Power-on reset
    #12;
    chk_all_zero("por");
    @(negedge clk);
    nRST = 1'b1;
    repeat (3) step(1'b0);
    chk("idle_wen", 128'(bus.aluWEN), 128'(0));

    // Round-robin with every entry ready and the ALU always available
    bus.rsReady  = 4'b1111;
    bus.aluAvail = 1'b1;
    q_exp.push_back(0); q_exp.push_back(1); q_exp.push_back(2);
    q_exp.push_back(3); q_exp.push_back(0);
    repeat (5) step(1'b1);
    bus.rsReady = '0;
    step(1'b0);
    chk("rr_drain_wen", 128'(bus.aluWEN), 128'(0));
    chk("rr_pending", 128'(q_exp.size()), 128'(0));
    chk("rr_issue_cnt", 128'(bus.issueCnt), STATS ? 128'(5) : 128'(0));

    // Mask: entry 2 still ready in its grant cycle must not be re-granted
    bus.rsReady = 4'b0100;
    q_exp.push_back(2);
    step(1'b1);
    step(1'b0);
    bus.rsReady = '0;
    step(1'b0);
    step(1'b0);
    chk("mask_wen", 128'(bus.aluWEN), 128'(0));
    chk("mask_pending", 128'(q_exp.size()), 128'(0));

    // Stall: sub op in the slot, ALU busy for two cycles
    bus.rsReady  = 4'b0010;
    bus.aluAvail = 1'b0;
    q_exp.push_back(1);
    step(1'b1);
    bus.rsReady = 4'b1001;
    step(1'b0);
    chk_slot("stall1", 1);
    step(1'b0);
    chk_slot("stall2", 1);
    chk("stall_cnt", 128'(bus.stallCnt), STATS ? 128'(2) : 128'(0));
    bus.aluAvail = 1'b1;
    q_exp.push_back(3);
    step(1'b1);
    bus.rsReady = '0;
    step(1'b0);
    chk("stall_drain_wen", 128'(bus.aluWEN), 128'(0));
    chk("stall_issue_cnt", 128'(bus.issueCnt), STATS ? 128'(8) : 128'(0));
    chk("stall_cnt_hold", 128'(bus.stallCnt), STATS ? 128'(2) : 128'(0));

    // Flush beats a simultaneous consume and blocks grants; ptr is kept
    bus.rsReady = 4'b0100;
    q_exp.push_back(2);
    step(1'b1);
    bus.rsReady = 4'b0011;
    bus.flush   = 1'b1;
    step(1'b0);
    chk("flush_wen", 128'(bus.aluWEN), 128'(0));
    chk("flush_issue_cnt", 128'(bus.issueCnt), STATS ? 128'(8) : 128'(0));
    bus.flush   = 1'b0;
    bus.rsReady = 4'b1111;
    q_exp.push_back(3);
    step(1'b1);
    bus.rsReady = '0;
    step(1'b0);
    chk("flush_pending", 128'(q_exp.size()), 128'(0));
    chk("flush_resume_cnt", 128'(bus.issueCnt), STATS ? 128'(9) : 128'(0));

    // Reset in the middle of an issue, then ptr must restart at 0
    bus.rsReady = 4'b1111;
    q_exp.push_back(0);
    step(1'b1);
    bus.rsReady = 4'b0011;
    #2;
    nRST = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    bus.rsReady = '0;
    @(negedge clk);
    nRST = 1'b1;
    step(1'b0);
    step(1'b0);
    chk("post_rst_wen", 128'(bus.aluWEN), 128'(0));
    bus.rsReady = 4'b1111;
    q_exp.push_back(0);
    step(1'b1);
    bus.rsReady = '0;
    step(1'b0);
    chk("rst_pending", 128'(q_exp.size()), 128'(0));

    // Issue counter saturation from 16'hFFFE
`ifdef ISSUE_STATS_EN
    force dut.r_issue_cnt = 16'hFFFE;
    #1;
    release dut.r_issue_cnt;
`endif
    bus.rsReady = 4'b0110;
    q_exp.push_back(1);
    q_exp.push_back(2);
    step(1'b1);
    step(1'b1);
    bus.rsReady = '0;
    step(1'b0);
    chk("sat_issue_cnt", 128'(bus.issueCnt), STATS ? 128'(16'hFFFF) : 128'(0));
    step(1'b0);
    chk("sat_issue_hold", 128'(bus.issueCnt), STATS ? 128'(16'hFFFF) : 128'(0));
    chk("sat_stall_cnt", 128'(bus.stallCnt), 128'(0));
    chk("final_pending", 128'(q_exp.size()), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
